// File: rtl/fpu_cordic_pkg.sv
// Shared CORDIC/FPU constants and types: FP80 field layout, Q2.62 fixed-point
// format, the fixed-to-FP80 converter state encoding and its helpers.
package fpu_cordic_pkg;

    localparam int unsigned FP80_EXP_BIAS    = 16383;
    localparam int unsigned CORDIC_FRAC_BITS = 62;

    localparam int unsigned FP80_SIGN_W = 1;
    localparam int unsigned FP80_EXP_W  = 15;
    localparam int unsigned FP80_MANT_W = 64;
    localparam int unsigned FP80_W      = FP80_SIGN_W + FP80_EXP_W + FP80_MANT_W;

    localparam int unsigned FIXED_W = 64;

    // Exponent of a magnitude whose MSB sits at bit FIXED_W-1 (0x4000 for Q2.62)
    localparam logic [FP80_EXP_W-1:0] FIX2FP_EXP_INIT =
        FP80_EXP_W'(FP80_EXP_BIAS + (FIXED_W - 1) - CORDIC_FRAC_BITS);

    typedef enum logic [1:0] {
        FIX2FP_IDLE = 2'd0,
        FIX2FP_NORM = 2'd1,
        FIX2FP_DONE = 2'd2
    } fixed2fp80_state_t;

    typedef struct packed {
        logic                   sign;
        logic [FP80_EXP_W-1:0]  exp;
        logic [FP80_MANT_W-1:0] mant;
    } fp80_t;

    // Magnitude of a two's-complement word; the most negative value maps to 2^(W-1)
    function automatic logic [FIXED_W-1:0] fixed_abs(input logic [FIXED_W-1:0] x);
        logic [FIXED_W-1:0] neg;
        neg = FIXED_W'(~x + FIXED_W'(1));
        return x[FIXED_W-1] ? neg : x;
    endfunction

endpackage

// File: rtl/fpu_fixed_to_fp80_if.sv
// Start/done handshake and data bus of the fixed-to-FP80 converter.
interface fpu_fixed_to_fp80_if;
    import fpu_cordic_pkg::*;

    logic                start;
    logic [FIXED_W-1:0]  fixed_in;
    logic [FP80_W-1:0]   fp80_out;
    logic                done;
    logic                busy;

    // Requester side
    modport master (
        output start,
        output fixed_in,
        input  fp80_out,
        input  done,
        input  busy
    );

    // Converter side
    modport slave (
        input  start,
        input  fixed_in,
        output fp80_out,
        output done,
        output busy
    );

endinterface

// File: rtl/fpu_fixed_to_fp80.sv
// Q2.62 signed fixed-point to FP80 converter with iterative normalization.
// Optional build macro FIXED2FP80_COARSE_SHIFT_EN: shift by 8 in one NORM cycle
// while the top byte of the magnitude is clear (same results, lower latency).
module fpu_fixed_to_fp80
    import fpu_cordic_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    fpu_fixed_to_fp80_if.slave bus
);

    localparam logic [1:0] ST_IDLE = FIX2FP_IDLE;
    localparam logic [1:0] ST_NORM = FIX2FP_NORM;
    localparam logic [1:0] ST_DONE = FIX2FP_DONE;

`ifdef FIXED2FP80_COARSE_SHIFT_EN
    localparam int unsigned COARSE_STEP = 8;
`endif

    logic [1:0]            state_q, state_d;
    logic                  sign_q,  sign_d;
    logic [FIXED_W-1:0]    mag_q,   mag_d;
    logic [FP80_EXP_W-1:0] exp_q,   exp_d;
    fp80_t                 fp80_q,  fp80_d;
    logic                  done_q,  done_d;
    logic                  busy_q,  busy_d;

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        mag_d   = mag_q;
        exp_d   = exp_q;
        fp80_d  = fp80_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    sign_d  = bus.fixed_in[FIXED_W-1];
                    mag_d   = fixed_abs(bus.fixed_in);
                    exp_d   = FIX2FP_EXP_INIT;
                    busy_d  = 1'b1;
                    state_d = ST_NORM;
                end
            end

            ST_NORM: begin
                busy_d = 1'b1;
                if ((mag_q == '0) || mag_q[FIXED_W-1]) begin
                    state_d = ST_DONE;
                end
`ifdef FIXED2FP80_COARSE_SHIFT_EN
                else if (mag_q[FIXED_W-1 -: COARSE_STEP] == '0) begin
                    mag_d = mag_q << COARSE_STEP;
                    exp_d = exp_q - FP80_EXP_W'(COARSE_STEP);
                end
`endif
                else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - FP80_EXP_W'(1);
                end
            end

            ST_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = ST_IDLE;
                // Zero is emitted as +0 regardless of the captured sign
                if (mag_q == '0) begin
                    fp80_d = '0;
                end else begin
                    fp80_d.sign = sign_q;
                    fp80_d.exp  = exp_q;
                    fp80_d.mant = mag_q;
                end
            end

            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            exp_q   <= '0;
            fp80_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            exp_q   <= exp_d;
            fp80_q  <= fp80_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.fp80_out = fp80_q;
    assign bus.done     = done_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_fpu_fixed_to_fp80.sv
// Directed vector bench for fpu_fixed_to_fp80 (both shift builds).
module tb_fpu_fixed_to_fp80;
    import fpu_cordic_pkg::*;

    logic clk;
    logic reset;

    fpu_fixed_to_fp80_if bus();

    fpu_fixed_to_fp80 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [63:0] fx;
        logic [79:0] res;
        int          lat_fine;
        int          lat_coarse;
    } vec_t;

    vec_t vecs [12];
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at posedge+1; start is sampled at the next edge
    task automatic start_op(input logic [63:0] fx);
        bus.start    = 1'b1;
        bus.fixed_in = fx;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    // Counts edges since the accept edge until done is seen, bounded
    task automatic wait_done(input int already, input string nm, output int lat);
        lat = already;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (bus.done !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done after %0d cycles expected done", nm, lat);
        end
    endtask

    function automatic int sel_lat(input int fine, input int coarse);
`ifdef FIXED2FP80_COARSE_SHIFT_EN
        return coarse;
`else
        return fine;
`endif
    endfunction

    initial begin
        int          lat;
        int          pulses;
        logic [79:0] prev;

        vecs[0]  = '{"one",      64'h4000_0000_0000_0000, 80'h3FFF_8000_0000_0000_0000,  3,  3};
        vecs[1]  = '{"neg_one",  64'hC000_0000_0000_0000, 80'hBFFF_8000_0000_0000_0000,  3,  3};
        vecs[2]  = '{"half",     64'h2000_0000_0000_0000, 80'h3FFE_8000_0000_0000_0000,  4,  4};
        vecs[3]  = '{"neg_two",  64'h8000_0000_0000_0000, 80'hC000_8000_0000_0000_0000,  2,  2};
        vecs[4]  = '{"zero",     64'h0000_0000_0000_0000, 80'h0000_0000_0000_0000_0000,  2,  2};
        vecs[5]  = '{"lsb",      64'h0000_0000_0000_0001, 80'h3FC1_8000_0000_0000_0000, 65, 16};
        vecs[6]  = '{"neg_lsb",  64'hFFFF_FFFF_FFFF_FFFF, 80'hBFC1_8000_0000_0000_0000, 65, 16};
        vecs[7]  = '{"max_pos",  64'h7FFF_FFFF_FFFF_FFFF, 80'h3FFF_FFFF_FFFF_FFFF_FFFE,  3,  3};
        vecs[8]  = '{"mid",      64'h0000_0000_0001_2345, 80'h3FD1_91A2_8000_0000_0000, 49, 14};
        vecs[9]  = '{"neg_256",  64'hFFFF_FFFF_FFFF_FF00, 80'hBFC9_8000_0000_0000_0000, 57, 15};
        vecs[10] = '{"bit56",    64'h0100_0000_0000_0000, 80'h3FF9_8000_0000_0000_0000,  9,  9};
        vecs[11] = '{"byte55",   64'h00FF_0000_0000_0000, 80'h3FF8_FF00_0000_0000_0000, 10,  3};

        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.fixed_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_fp80", bus.fp80_out, 80'h0);
        chk("rst_done", 80'(bus.done), 80'h0);
        chk("rst_busy", 80'(bus.busy), 80'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        prev = 80'h0;
        for (int i = 0; i < 12; i++) begin
            start_op(vecs[i].fx);
            chk({vecs[i].name, "_busy_start"}, 80'(bus.busy), 80'h1);
            chk({vecs[i].name, "_hold"}, bus.fp80_out, prev);
            wait_done(0, vecs[i].name, lat);
            chk({vecs[i].name, "_result"}, bus.fp80_out, vecs[i].res);
            chk({vecs[i].name, "_latency"}, 80'(lat),
                80'(sel_lat(vecs[i].lat_fine, vecs[i].lat_coarse)));
            chk({vecs[i].name, "_busy_done"}, 80'(bus.busy), 80'h1);
            @(posedge clk); #1;
            chk({vecs[i].name, "_done_pulse"}, 80'(bus.done), 80'h0);
            chk({vecs[i].name, "_busy_end"}, 80'(bus.busy), 80'h0);
            prev = vecs[i].res;
        end

        // Back-to-back: second start raised during the done cycle
        start_op(64'h2000_0000_0000_0000);
        wait_done(0, "b2b_first", lat);
        chk("b2b_first_result", bus.fp80_out, 80'h3FFE_8000_0000_0000_0000);
        start_op(64'hC000_0000_0000_0000);
        chk("b2b_busy", 80'(bus.busy), 80'h1);
        chk("b2b_hold", bus.fp80_out, 80'h3FFE_8000_0000_0000_0000);
        wait_done(0, "b2b_second", lat);
        chk("b2b_second_result", bus.fp80_out, 80'hBFFF_8000_0000_0000_0000);
        chk("b2b_second_latency", 80'(lat), 80'd3);
        @(posedge clk); #1;

        // Start while busy is ignored
        start_op(64'h2000_0000_0000_0000);
        @(posedge clk); #1;
        bus.start    = 1'b1;
        bus.fixed_in = 64'h4000_0000_0000_0000;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        wait_done(2, "ignore", lat);
        chk("ignore_result", bus.fp80_out, 80'h3FFE_8000_0000_0000_0000);
        chk("ignore_latency", 80'(lat), 80'd4);
        pulses = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) pulses++;
        end
        chk("ignore_extra_done", 80'(pulses), 80'd0);
        chk("ignore_idle_busy", 80'(bus.busy), 80'h0);

        // Reset mid-NORM, then reset together with start
        start_op(64'h0000_0000_0000_0001);
        repeat (10) @(posedge clk);
        #1;
        chk("midrst_busy_before", 80'(bus.busy), 80'h1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_busy", 80'(bus.busy), 80'h0);
        chk("midrst_done", 80'(bus.done), 80'h0);
        chk("midrst_fp80", bus.fp80_out, 80'h0);
        bus.start    = 1'b1;
        bus.fixed_in = 64'h4000_0000_0000_0000;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        chk("rst_start_busy", 80'(bus.busy), 80'h0);
        @(posedge clk); #1;
        chk("rst_start_not_taken", 80'(bus.busy), 80'h0);
        start_op(64'h4000_0000_0000_0000);
        wait_done(0, "post_rst", lat);
        chk("post_rst_result", bus.fp80_out, 80'h3FFF_8000_0000_0000_0000);
        chk("post_rst_latency", 80'(lat), 80'd3);
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_fixed_to_fp80.md
# fpu_fixed_to_fp80

Sequential converter from the CORDIC engine's signed Q2.62 fixed-point result format back to 80-bit extended-precision (FP80) values. It is the return path of the FP80-to-fixed conversion in the CORDIC datapath: the sin/cos/atan/magnitude fixed-point outputs pass through this block before they reach the FPU register stack. Normalization runs iteratively under a start/done handshake, with no combinational leading-zero counter.

## Interface
- FRAC_BITS, 62: fractional bits of the input fixed-point word (value = fixed_in / 2^FRAC_BITS).
- EXP_BIAS, 16383: FP80 exponent bias.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while idle.
- fixed_in  in  64  two's-complement Q2.62 operand; sampled on the accepted-start edge.
- fp80_out  out  80  result: [79] sign, [78:64] biased exponent, [63:0] mantissa with explicit integer bit.
- done  out  1  one-cycle pulse when fp80_out becomes valid.
- busy  out  1  high from the cycle after an accepted start until the done cycle (inclusive).

## Operation
- States: IDLE, NORM, DONE.
- IDLE: if start=1, register sign=fixed_in[63], mag=|fixed_in| (64-bit unsigned; -2^63 gives 0x8000_0000_0000_0000), exp=EXP_BIAS+63-FRAC_BITS (0x4000). Go to NORM.
- NORM, one decision per cycle:
  - mag==0: result = 80'h0 (sign forced 0, so -0 never occurs). Go to DONE.
  - mag[63]==1: result = {sign, exp[14:0], mag}. Go to DONE.
  - otherwise: mag<<=1, exp-=1. Stay in NORM.
- DONE: register fp80_out, pulse done, return to IDLE.
- fp80_out holds its value until the next DONE. It does not change when a new start is accepted.
- start while busy is ignored, not queued.
- No rounding is needed: the magnitude always fits the 64-bit mantissa exactly.
- Exponent range is 0x3FC1 to 0x4000. No overflow or denormal cases exist.

## Timing
- Reset values: fp80_out=80'h0, done=0, busy=0, state=IDLE.
- Latency from the accepted-start edge to done high = 2 + S clocks, where S is the number of NORM shift cycles.
- Without coarse shifting, S = 63 - p, where p is the MSB index of mag. S = 0 for zero input.
- Minimum latency is 2: inputs with mag[63]=1 and zero input.
- Maximum latency is 65: fixed_in = 1.
- Back-to-back: start may be asserted in the same cycle done is high. It is accepted on the following edge because the state is IDLE then.
- Reset during NORM or DONE: the next cycle is IDLE, busy=0, done=0, fp80_out=0. The partial result is discarded.
- start and reset high together: reset wins; the start is not accepted.

## Configuration
- FIXED2FP80_COARSE_SHIFT_EN:
  - Defined: in NORM, when mag!=0 and mag[63:56]==0, shift left by 8 and decrement exp by 8 in one cycle; otherwise apply the single-bit rule. S = floor((63-p)/8) + ((63-p) mod 8). Worst case (fixed_in=1) latency is 2+14=16.
  - Undefined: one bit per cycle only. Results are bit-identical in both builds; only latency differs.

## Structure
- Shared package fpu_cordic_pkg holds:
  - FP80_EXP_BIAS=16383 and CORDIC_FRAC_BITS=62;
  - the FP80 field-width constants (sign 1, exponent 15, mantissa 64);
  - the state enum type fixed2fp80_state_t (IDLE, NORM, DONE).
- No sub-module. Absolute value, shifter and exponent decrement are small enough to live in this one always block plus next-state logic.

## Test plan
- Reset, then fixed_in=64'h4000_0000_0000_0000 (1.0) -> fp80_out=80'h3FFF_8000000000000000, done 3 cycles after start.
- fixed_in=64'hC000_0000_0000_0000 (-1.0) -> 80'hBFFF_8000000000000000; fixed_in=64'h2000_0000_0000_0000 (0.5) -> 80'h3FFE_8000000000000000, latency 4.
- fixed_in=64'h8000_0000_0000_0000 (-2.0) -> 80'hC000_8000000000000000, latency 2; fixed_in=0 -> 80'h0, latency 2.
- fixed_in=64'h1 -> 80'h3FC1_8000000000000000, latency 65 (16 with FIXED2FP80_COARSE_SHIFT_EN).
- Start with 0.5; pulse start again while busy with 1.0 -> the second start is ignored, output is the 0.5 result, a single done pulse.
- Assert reset mid-NORM -> next cycle busy=0, done=0, fp80_out=0; a following start with 1.0 completes normally.
